// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the fetch/sequencing path of the multicycle datapath.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    function automatic word_t sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and register-indirect targets.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  logic [1:0]  PCsrc,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    input  word_t       rs_data,
    output word_t       npc,
    output word_t       pc_plus4
);

    word_t branch_target;
    word_t jump_target;
    word_t jr_target;

    // All arithmetic is 32-bit modular; wrap-around past 0xFFFF_FFFC is intended.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + (sign_ext16(imm) << 2);
    assign jump_target   = {pc_plus4[31:28], addr, 2'b00};
    assign jr_target     = {rs_data[31:2], 2'b00};

    always_comb begin
        // NOTE: default first so every path assigns npc and no latch is inferred.
        npc = pc_plus4;
        case (PCsrc)
            PC_SEQ:  npc = pc_plus4;
            PC_BR:   npc = branch_target;
            PC_JMP:  npc = jump_target;
            PC_JR:   npc = jr_target;
            default: npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing: owns the PC, latches the fetched word and gates data requests.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  word_t       iload,
    input  logic        dhit,
    input  logic [1:0]  PCsrc,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    input  word_t       rs_data,
    input  logic        halt,
    input  logic        dREN,
    input  logic        dWEN,
    output word_t       imemaddr,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output word_t       instr,
    output logic        instr_valid,
    output word_t       pc_plus4,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t next_state;
    word_t        pc;
    word_t        npc;
    logic         data_req;
    logic         leave_exec;

    next_pc_calc u_next_pc (
        .pc       (pc),
        .PCsrc    (PCsrc),
        .imm      (imm),
        .addr     (addr),
        .rs_data  (rs_data),
        .npc      (npc),
        .pc_plus4 (pc_plus4)
    );

    assign data_req = dREN | dWEN;
    // An instruction retires from EXEC when not halting and its data access (if any) has completed.
    assign leave_exec = (state == EXEC) && !halt && (!data_req || dhit);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (ihit) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (leave_exec) begin
                    next_state = FETCH;
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are forced idle while reset is held, even before the reset edge lands.
    always_comb begin
        imemREN     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        if (!RST) begin
            case (state)
                FETCH: imemREN = 1'b1;
                EXEC: begin
                    instr_valid = 1'b1;
                    dmemREN     = dREN && !halt;
                    dmemWEN     = dWEN && !halt;
                end
                HALTED:  halted = 1'b1;
                default: imemREN = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc <= PC_INIT;
        end else if (leave_exec) begin
            pc <= npc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr <= '0;
        end else if (state == FETCH && ihit) begin
            instr <= iload;
        end
    end

    assign imemaddr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected instr/PC pairs, a monitor checks each EXEC entry.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    typedef struct {
        word_t instr;
        word_t pc;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        ihit;
    word_t       iload;
    logic        dhit;
    logic [1:0]  PCsrc;
    logic [15:0] imm;
    logic [25:0] addr;
    word_t       rs_data;
    logic        halt;
    logic        dREN;
    logic        dWEN;
    word_t       imemaddr;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    word_t       instr;
    logic        instr_valid;
    word_t       pc_plus4;
    logic        halted;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .iload       (iload),
        .dhit        (dhit),
        .PCsrc       (PCsrc),
        .imm         (imm),
        .addr        (addr),
        .rs_data     (rs_data),
        .halt        (halt),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .imemaddr    (imemaddr),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every entry into EXEC, compare the latched word and the PC it was fetched from.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            if (instr_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got unexpected instr %h expected none", instr);
                end else begin
                    e = sb.pop_front();
                    check("instr", instr, e.instr);
                    check("exec_pc", imemaddr, e.pc);
                    check("pc_plus4", pc_plus4, e.pc + 32'd4);
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_ctrl();
        PCsrc   = PC_SEQ;
        imm     = '0;
        addr    = '0;
        rs_data = '0;
        halt    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        dhit    = 1'b0;
    endtask

    // Called just after a negedge with the DUT in FETCH; returns just after a negedge.
    // Data-free, non-halting instructions return in FETCH; halting ones return in EXEC.
    task automatic issue(input word_t word, input word_t pc_exp, input logic [1:0] src,
                         input logic [15:0] i_imm, input logic [25:0] i_addr, input word_t i_rs,
                         input logic i_halt, input logic i_dren, input logic i_dwen,
                         input int dly, input int fetch_wait);
        sb.push_back('{word, pc_exp});
        repeat (fetch_wait) @(negedge CLK);
        ihit    = 1'b1;
        iload   = word;
        PCsrc   = src;
        imm     = i_imm;
        addr    = i_addr;
        rs_data = i_rs;
        halt    = i_halt;
        dREN    = i_dren;
        dWEN    = i_dwen;
        @(negedge CLK);
        ihit  = 1'b0;
        iload = 32'hDEAD_BEEF;
        if (i_halt) return;
        if (i_dren || i_dwen) begin
            for (int k = 0; k <= dly; k++) begin
                #1;
                check("dmemREN_exec", {31'd0, dmemREN}, {31'd0, i_dren});
                check("dmemWEN_exec", {31'd0, dmemWEN}, {31'd0, i_dwen});
                check("pc_hold", imemaddr, pc_exp);
                if (k == dly) dhit = 1'b1;
                @(negedge CLK);
            end
        end else begin
            @(negedge CLK);
        end
        clear_ctrl();
        #1;
        check("back_to_fetch", {31'd0, imemREN}, 32'd1);
        check("dmem_idle", {30'd0, dmemREN, dmemWEN}, 32'd0);
    endtask

    initial begin
        ihit  = 1'b0;
        iload = 32'hDEAD_BEEF;
        clear_ctrl();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_pc", imemaddr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_imemREN", {31'd0, imemREN}, 32'd0);
        check("rst_flags", {28'd0, instr_valid, halted, dmemREN, dmemWEN}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post_rst_imemREN", {31'd0, imemREN}, 32'd1);
        check("post_rst_pc", imemaddr, 32'h0);

        // ihit on the second FETCH cycle, then the branch/jump/jr target chain.
        issue(32'h2001_0005, 32'h0000_0000, PC_SEQ, 16'h0,    26'h0,  32'h0,         0, 0, 0, 0, 1);
        check("seq_next", imemaddr, 32'h0000_0004);
        check("instr_hold", instr, 32'h2001_0005);
        issue(32'h0000_0008, 32'h0000_0004, PC_JR,  16'h0,    26'h0,  32'h0000_0040, 0, 0, 0, 0, 0);
        issue(32'h1000_FFFE, 32'h0000_0040, PC_BR,  16'hFFFE, 26'h0,  32'h0,         0, 0, 0, 0, 2);
        check("br_back", imemaddr, 32'h0000_003C);
        issue(32'h0000_0011, 32'h0000_003C, PC_JR,  16'h0,    26'h0,  32'h0000_0040, 0, 0, 0, 0, 0);
        issue(32'h1000_0003, 32'h0000_0040, PC_BR,  16'h0003, 26'h0,  32'h0,         0, 0, 0, 0, 0);
        check("br_fwd", imemaddr, 32'h0000_0050);
        issue(32'h0000_0022, 32'h0000_0050, PC_JR,  16'h0,    26'h0,  32'h1000_0000, 0, 0, 0, 0, 0);
        issue(32'h0800_0010, 32'h1000_0000, PC_JMP, 16'h0,    26'h10, 32'h0,         0, 0, 0, 0, 0);
        check("jmp", imemaddr, 32'h1000_0040);
        issue(32'h0000_0033, 32'h1000_0040, PC_JR,  16'h0,    26'h0,  32'h0000_0123, 0, 0, 0, 0, 0);
        check("jr_align", imemaddr, 32'h0000_0120);

        // Store with dhit three cycles late: dmemWEN high for four EXEC cycles.
        issue(32'hAC22_0000, 32'h0000_0120, PC_SEQ, 16'h0,    26'h0,  32'h0,         0, 0, 1, 3, 0);
        check("after_store", imemaddr, 32'h0000_0124);

        // Store interrupted by reset mid-wait; a stale dhit afterwards is ignored.
        sb.push_back('{32'hAC33_0000, 32'h0000_0124});
        ihit  = 1'b1;
        iload = 32'hAC33_0000;
        PCsrc = PC_SEQ;
        dWEN  = 1'b1;
        @(negedge CLK);
        ihit = 1'b0;
        repeat (2) begin
            #1;
            check("wait_dmemWEN", {31'd0, dmemWEN}, 32'd1);
            @(negedge CLK);
        end
        RST = 1'b1;
        #1;
        check("rst_gate_dmemWEN", {31'd0, dmemWEN}, 32'd0);
        @(negedge CLK);
        #1;
        check("mid_rst_pc", imemaddr, 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_flags", {28'd0, instr_valid, halted, dmemREN, dmemWEN}, 32'd0);
        dWEN = 1'b0;
        RST  = 1'b0;
        dhit = 1'b1;
        @(negedge CLK);
        dhit = 1'b0;
        #1;
        check("stale_dhit_pc", imemaddr, 32'h0);
        check("stale_dhit_fetch", {31'd0, imemREN}, 32'd1);

        // Wrap-around from the top of the address space.
        issue(32'h0000_0044, 32'h0000_0000, PC_JR,  16'h0,    26'h0,  32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        check("jr_top", imemaddr, 32'hFFFF_FFFC);
        issue(32'h0000_0055, 32'hFFFF_FFFC, PC_SEQ, 16'h0,    26'h0,  32'h0,         0, 0, 0, 0, 0);
        check("wrap", imemaddr, 32'h0000_0000);

        // Halt with a simultaneous load request: no data access, terminal state.
        issue(32'h0000_000C, 32'h0000_0000, PC_JR,  16'h0,    26'h0,  32'h0000_0500, 1, 1, 0, 0, 0);
        #1;
        check("halt_no_dmemREN", {31'd0, dmemREN}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            ihit = i[0];
            dhit = ~i[0];
            #1;
            check("halted", {31'd0, halted}, 32'd1);
            check("halted_idle", {28'd0, imemREN, dmemREN, dmemWEN, instr_valid}, 32'd0);
            check("halted_pc", imemaddr, 32'h0);
        end
        ihit = 1'b0;
        dhit = 1'b0;

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
